pipeline_cmd_issuer: RTL and testbench

Command-side initiator for `dsp_pipeline`. It parses a framed byte stream from the host link (SPI/UART front end) into pipeline control transactions. It drives the instruction-write, register-write/update, commit, delay-alloc and full-reset strobes, and waits for the pipeline's acknowledgements. It sits between the host byte transport and the pipeline's control ports, and is the only writer of those ports.

---
 rtl/pipeline_cmd_issuer_pkg.sv | 47 ++++
 rtl/pipeline_cmd_issuer_shift_rx.sv | 36 +++
 rtl/pipeline_cmd_issuer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pipeline_cmd_issuer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_cmd_issuer_pkg.sv
// Shared constants for pipeline_cmd_issuer: opcodes, error codes, FSM encodings
// and payload-length helpers.
package pipeline_cmd_issuer_pkg;

  localparam logic [7:0] OP_INSTR      = 8'h01;
  localparam logic [7:0] OP_REG_WRITE  = 8'h02;
  localparam logic [7:0] OP_REG_UPDATE = 8'h03;
  localparam logic [7:0] OP_COMMIT     = 8'h04;
  localparam logic [7:0] OP_ALLOC      = 8'h05;
  localparam logic [7:0] OP_FULL_RESET = 8'h06;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_BAD_OP = 3'd1;
  localparam logic [2:0] ERR_ACK_TO = 3'd2;
  localparam logic [2:0] ERR_RST_TO = 3'd3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PAYLOAD  = 2'd1;
  localparam logic [1:0] ST_ISSUE    = 2'd2;
  localparam logic [1:0] ST_WAIT_ACK = 2'd3;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op >= OP_INSTR) && (op <= OP_FULL_RESET);
  endfunction

  function automatic int unsigned payload_len(input logic [7:0] op,
                                              input int unsigned dw,
                                              input int unsigned iw);
    case (op)
      OP_INSTR:      return 1 + iw / 8;
      OP_REG_WRITE:  return 2 + dw / 8;
      OP_REG_UPDATE: return 2 + dw / 8;
      OP_ALLOC:      return (2 * dw) / 8;
      default:       return 0;
    endcase
  endfunction

  function automatic int unsigned max_len(input int unsigned dw,
                                          input int unsigned iw);
    int unsigned m;
    m = 1 + iw / 8;
    if (2 + dw / 8 > m) m = 2 + dw / 8;
    if ((2 * dw) / 8 > m) m = (2 * dw) / 8;
    return m;
  endfunction

endpackage

// File: rtl/pipeline_cmd_issuer_shift_rx.sv
// Payload receiver: byte down-counter plus MSB-first shift register.
// data_nxt exposes the register including the byte being shifted this cycle.
module cmd_shift_rx #(
  parameter int unsigned MAX_BYTES = 5,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [CNT_W-1:0]       load_len,
  input  logic                   shift,
  input  logic [7:0]             byte_in,
  output logic [8*MAX_BYTES-1:0] data_nxt,
  output logic                   done
);

  logic [CNT_W-1:0]       cnt_q;
  logic [8*MAX_BYTES-1:0] data_q;

  assign data_nxt = {data_q[8*MAX_BYTES-9:0], byte_in};
  assign done     = shift && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else if (load) begin
      cnt_q  <= load_len;
      data_q <= '0;
    end else if (shift) begin
      cnt_q  <= cnt_q - CNT_W'(1);
      data_q <= data_nxt;
    end
  end

endmodule

// File: rtl/pipeline_cmd_issuer.sv
// Host byte-stream to dsp_pipeline control-strobe issuer.
// Optional ack/reset timeout is enabled by defining CMD_ACK_TIMEOUT_EN.
module pipeline_cmd_issuer
  import pipeline_cmd_issuer_pkg::*;
#(
  parameter int unsigned data_width     = 16,
  parameter int unsigned n_blocks       = 256,
  parameter int unsigned reg_addr_width = 1,
  parameter int unsigned instr_width    = 32,
  parameter int unsigned timeout_cycles = 4096
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [7:0]                            in_byte,
  input  logic                                  in_byte_valid,
  output logic                                  in_byte_ready,
  output logic [$clog2(n_blocks)-1:0]           block_target,
  output logic [$clog2(n_blocks)+reg_addr_width-1:0] reg_target,
  output logic [instr_width-1:0]                instr_val,
  output logic [data_width-1:0]                 ctrl_data,
  output logic [2*data_width-1:0]               buf_init_delay,
  output logic                                  instr_write,
  output logic                                  reg_write,
  output logic                                  reg_update,
  output logic                                  reg_writes_commit,
  output logic                                  alloc_delay,
  output logic                                  full_reset,
  input  logic                                  instr_write_ack,
  input  logic                                  reg_write_ack,
  input  logic                                  resetting,
  output logic                                  busy,
  output logic                                  error,
  output logic [2:0]                            err_code,
  output logic [15:0]                           cmd_count
);

  localparam int unsigned BW      = $clog2(n_blocks);
  localparam int unsigned RTW     = BW + reg_addr_width;
  localparam int unsigned MAX_LEN = max_len(data_width, instr_width);
  localparam int unsigned SH_W    = 8 * MAX_LEN;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  logic [1:0]              state_q, state_d;
  logic [7:0]              cmd_q, cmd_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;
  logic [2:0]              err_q, err_d;
  logic [15:0]             count_q, count_d;
  logic                    seen_q, seen_d;
  logic [BW-1:0]           blk_q, blk_d;
  logic [RTW-1:0]          rt_q, rt_d;
  logic [instr_width-1:0]  instr_q, instr_d;
  logic [data_width-1:0]   data_q, data_d;
  logic [2*data_width-1:0] dly_q, dly_d;
  logic [5:0]              stb_q, stb_d;

`ifdef CMD_ACK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(timeout_cycles + 1);
  logic [TO_W-1:0] to_q, to_d;
`endif

  logic             accept;
  logic             ld, sh;
  logic [CNT_W-1:0] ld_len;
  logic [SH_W-1:0]  sh_nxt;
  logic             rx_done;
  logic             go_issue;
  logic [7:0]       iss_op;
  logic             ack_done;
  int unsigned      plen;
  logic             unused_sh;

  cmd_shift_rx #(
    .MAX_BYTES (MAX_LEN),
    .CNT_W     (CNT_W)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .load_len (ld_len),
    .shift    (sh),
    .byte_in  (in_byte),
    .data_nxt (sh_nxt),
    .done     (rx_done)
  );

  assign accept    = in_byte_valid && ready_q;
  assign unused_sh = ^sh_nxt;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    error_d  = error_q;
    err_d    = err_q;
    count_d  = count_q;
    seen_d   = seen_q;
    blk_d    = blk_q;
    rt_d     = rt_q;
    instr_d  = instr_q;
    data_d   = data_q;
    dly_d    = dly_q;
    stb_d    = '0;
    ld       = 1'b0;
    sh       = 1'b0;
    go_issue = 1'b0;
    iss_op   = cmd_q;
    ack_done = 1'b0;
    plen     = payload_len(in_byte, data_width, instr_width);
    ld_len   = CNT_W'(plen);
`ifdef CMD_ACK_TIMEOUT_EN
    to_d     = to_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_known_op(in_byte)) begin
            error_d = 1'b1;
            err_d   = ERR_BAD_OP;
          end else begin
            cmd_d = in_byte;
            if (plen == 0) begin
              go_issue = 1'b1;
              iss_op   = in_byte;
            end else begin
              ld      = 1'b1;
              state_d = ST_PAYLOAD;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          sh = 1'b1;
          if (rx_done) go_issue = 1'b1;
        end
      end
      ST_ISSUE: begin
        seen_d = 1'b0;
`ifdef CMD_ACK_TIMEOUT_EN
        to_d = '0;
`endif
        if (cmd_q == OP_INSTR || cmd_q == OP_REG_WRITE || cmd_q == OP_FULL_RESET) begin
          state_d = ST_WAIT_ACK;
        end else begin
          state_d = ST_IDLE;
          count_d = count_q + 16'd1;
        end
      end
      default: begin
        case (cmd_q)
          OP_INSTR:     ack_done = instr_write_ack;
          OP_REG_WRITE: ack_done = reg_write_ack;
          default: begin
            // FULL_RESET completes on the first low cycle after resetting was seen high
            if (resetting) seen_d = 1'b1;
            ack_done = seen_q && !resetting;
          end
        endcase
        if (ack_done) begin
          state_d = ST_IDLE;
          count_d = count_q + 16'd1;
        end else begin
`ifdef CMD_ACK_TIMEOUT_EN
          if (to_q == TO_W'(timeout_cycles - 1)) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
            err_d   = (cmd_q == OP_FULL_RESET) ? ERR_RST_TO : ERR_ACK_TO;
          end else begin
            to_d = to_q + TO_W'(1);
          end
`endif
        end
      end
    endcase

    // Strobe and shadow outputs are registered on entry to ISSUE, so the
    // payload is taken from the shifter's next value including this byte.
    if (go_issue) begin
      state_d = ST_ISSUE;
      case (iss_op)
        OP_INSTR: begin
          stb_d[0] = 1'b1;
          blk_d    = sh_nxt[instr_width +: BW];
          instr_d  = sh_nxt[instr_width-1:0];
        end
        OP_REG_WRITE, OP_REG_UPDATE: begin
          if (iss_op == OP_REG_WRITE) stb_d[1] = 1'b1;
          else                        stb_d[2] = 1'b1;
          blk_d  = sh_nxt[data_width+8 +: BW];
          rt_d   = {sh_nxt[data_width+8 +: BW], sh_nxt[data_width +: reg_addr_width]};
          data_d = sh_nxt[data_width-1:0];
        end
        OP_COMMIT: stb_d[3] = 1'b1;
        OP_ALLOC: begin
          stb_d[4] = 1'b1;
          dly_d    = sh_nxt[2*data_width-1:0];
        end
        default: stb_d[5] = 1'b1;
      endcase
    end

    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE) || (state_d == ST_PAYLOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= ERR_NONE;
      count_q <= '0;
      seen_q  <= 1'b0;
      blk_q   <= '0;
      rt_q    <= '0;
      instr_q <= '0;
      data_q  <= '0;
      dly_q   <= '0;
      stb_q   <= '0;
`ifdef CMD_ACK_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      error_q <= error_d;
      err_q   <= err_d;
      count_q <= count_d;
      seen_q  <= seen_d;
      blk_q   <= blk_d;
      rt_q    <= rt_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      dly_q   <= dly_d;
      stb_q   <= stb_d;
`ifdef CMD_ACK_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign in_byte_ready     = ready_q;
  assign busy              = busy_q;
  assign error             = error_q;
  assign err_code          = err_q;
  assign cmd_count         = count_q;
  assign block_target      = blk_q;
  assign reg_target        = rt_q;
  assign instr_val         = instr_q;
  assign ctrl_data         = data_q;
  assign buf_init_delay    = dly_q;
  assign instr_write       = stb_q[0];
  assign reg_write         = stb_q[1];
  assign reg_update        = stb_q[2];
  assign reg_writes_commit = stb_q[3];
  assign alloc_delay       = stb_q[4];
  assign full_reset        = stb_q[5];

endmodule

// File: tb/tb_pipeline_cmd_issuer.sv
// Scoreboard bench for pipeline_cmd_issuer: stimulus pushes expected strobes and
// completion counts; negedge monitors pop and compare when the DUT presents them.
module tb_pipeline_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = '0;
  logic        in_byte_valid = 1'b0;
  logic        in_byte_ready;
  logic [7:0]  block_target;
  logic [8:0]  reg_target;
  logic [31:0] instr_val;
  logic [15:0] ctrl_data;
  logic [31:0] buf_init_delay;
  logic        instr_write, reg_write, reg_update, reg_writes_commit, alloc_delay, full_reset;
  logic        instr_write_ack = 1'b0;
  logic        reg_write_ack = 1'b0;
  logic        resetting = 1'b0;
  logic        busy, error;
  logic [2:0]  err_code;
  logic [15:0] cmd_count;

  always #5 clk = ~clk;

  pipeline_cmd_issuer #(
    .data_width     (16),
    .n_blocks       (256),
    .reg_addr_width (1),
    .instr_width    (32),
    .timeout_cycles (4096)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_byte           (in_byte),
    .in_byte_valid     (in_byte_valid),
    .in_byte_ready     (in_byte_ready),
    .block_target      (block_target),
    .reg_target        (reg_target),
    .instr_val         (instr_val),
    .ctrl_data         (ctrl_data),
    .buf_init_delay    (buf_init_delay),
    .instr_write       (instr_write),
    .reg_write         (reg_write),
    .reg_update        (reg_update),
    .reg_writes_commit (reg_writes_commit),
    .alloc_delay       (alloc_delay),
    .full_reset        (full_reset),
    .instr_write_ack   (instr_write_ack),
    .reg_write_ack     (reg_write_ack),
    .resetting         (resetting),
    .busy              (busy),
    .error             (error),
    .err_code          (err_code),
    .cmd_count         (cmd_count)
  );

  localparam logic [5:0] S_INSTR = 6'b000001;
  localparam logic [5:0] S_RW    = 6'b000010;
  localparam logic [5:0] S_RU    = 6'b000100;
  localparam logic [5:0] S_CM    = 6'b001000;
  localparam logic [5:0] S_AL    = 6'b010000;
  localparam logic [5:0] S_FR    = 6'b100000;

  typedef struct {
    logic [5:0]  stb;
    logic [7:0]  blk;
    logic [8:0]  rt;
    logic [31:0] instr;
    logic [15:0] data;
    logic [31:0] dly;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] cnt_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_acc = -1;
  logic [15:0] prev_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [5:0] stb, input logic [7:0] blk, input logic [8:0] rt,
                          input logic [31:0] instr, input logic [15:0] data, input logic [31:0] dly);
    exp_t e;
    e.stb = stb; e.blk = blk; e.rt = rt; e.instr = instr; e.data = data; e.dly = dly;
    exp_q.push_back(e);
  endtask

  // Caller is at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_byte = b;
    in_byte_valid = 1'b1;
    while (!in_byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_byte_ready) begin
      checks++; errors++;
      $display("FAIL send_byte: byte %0h never accepted", b);
    end else begin
      last_acc = cyc;
    end
    @(negedge clk);
    in_byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_byte(v[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe monitor: one-hot, one cycle, strobe at last-accept+1, correct shadow values.
  always @(negedge clk) begin
    logic [5:0] stb;
    exp_t e;
    stb = {full_reset, alloc_delay, reg_writes_commit, reg_update, reg_write, instr_write};
    if (!reset && stb !== 6'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {58'b0, stb}, 64'b0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", {58'b0, stb}, {58'b0, e.stb});
        chk("strobe_latency", cyc, last_acc + 1);
        if (e.stb == S_INSTR) begin
          chk("instr_block", {56'b0, block_target}, {56'b0, e.blk});
          chk("instr_val", {32'b0, instr_val}, {32'b0, e.instr});
        end
        if (e.stb == S_RW || e.stb == S_RU) begin
          chk("reg_block", {56'b0, block_target}, {56'b0, e.blk});
          chk("reg_target", {55'b0, reg_target}, {55'b0, e.rt});
          chk("ctrl_data", {48'b0, ctrl_data}, {48'b0, e.data});
        end
        if (e.stb == S_AL) chk("buf_init_delay", {32'b0, buf_init_delay}, {32'b0, e.dly});
      end
    end
  end

  // Completion monitor: every cmd_count change must match the next expected count.
  always @(negedge clk) begin
    if (reset) begin
      prev_cnt = '0;
    end else if (cmd_count !== prev_cnt) begin
      if (cnt_q.size() == 0) chk("unexpected_count", {48'b0, cmd_count}, {48'b0, prev_cnt});
      else                   chk("cmd_count", {48'b0, cmd_count}, {48'b0, cnt_q.pop_front()});
      chk("idle_at_count", {63'b0, busy}, 64'b0);
      prev_cnt = cmd_count;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'b0, in_byte_ready}, 64'b0);
    chk("rst_strobes", {58'b0, full_reset, alloc_delay, reg_writes_commit, reg_update, reg_write, instr_write}, 64'b0);
    chk("rst_status", {44'b0, busy, error, err_code, cmd_count}, 64'b0);
    chk("rst_targets", {23'b0, block_target, reg_target, ctrl_data}, 64'b0);
    chk("rst_values", {instr_val, buf_init_delay}, 64'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {63'b0, in_byte_ready}, 64'd1);

    // INSTR, ack three cycles after the strobe
    push_exp(S_INSTR, 8'h05, '0, 32'hDEADBEEF, '0, '0);
    cnt_q.push_back(16'd1);
    send_frame(64'h01_05_DE_AD_BE_EF, 6);
    chk("instr_ready_issue", {63'b0, in_byte_ready}, 64'b0);
    idle(3);
    instr_write_ack = 1'b1;
    chk("instr_ready_wait", {63'b0, in_byte_ready}, 64'b0);
    @(negedge clk);
    instr_write_ack = 1'b0;
    chk("instr_ready_done", {63'b0, in_byte_ready}, 64'd1);
    chk("instr_count", {48'b0, cmd_count}, 64'd1);

    // REG_WRITE: ack on strobe cycle and stray instr ack both ignored
    push_exp(S_RW, 8'h03, 9'h007, '0, 16'h1234, '0);
    cnt_q.push_back(16'd2);
    send_frame(64'h02_03_01_12_34, 5);
    reg_write_ack = 1'b1;
    @(negedge clk);
    reg_write_ack = 1'b0;
    instr_write_ack = 1'b1;
    @(negedge clk);
    instr_write_ack = 1'b0;
    chk("rw_busy_stray", {63'b0, busy}, 64'd1);
    @(negedge clk);
    chk("rw_busy_wait", {63'b0, busy}, 64'd1);
    reg_write_ack = 1'b1;
    @(negedge clk);
    reg_write_ack = 1'b0;
    chk("rw_done", {63'b0, busy}, 64'b0);

    // REG_UPDATE completes without ack
    push_exp(S_RU, 8'h02, 9'h004, '0, 16'hABCD, '0);
    cnt_q.push_back(16'd3);
    send_frame(64'h03_02_00_AB_CD, 5);
    idle(1);
    chk("ru_done", {63'b0, busy}, 64'b0);

    // ALLOC then COMMIT back-to-back
    push_exp(S_AL, '0, '0, '0, '0, 32'h0000_0100);
    push_exp(S_CM, '0, '0, '0, '0, '0);
    cnt_q.push_back(16'd4);
    cnt_q.push_back(16'd5);
    send_frame(64'h05_00_00_01_00, 5);
    t = last_acc;
    send_byte(8'h04);
    chk("alloc_commit_gap", last_acc - t, 64'd2);
    idle(2);
    chk("commit_count", {48'b0, cmd_count}, 64'd5);

    // Unknown opcode, then a valid COMMIT
    send_byte(8'h7F);
    chk("badop_error", {63'b0, error}, 64'd1);
    chk("badop_code", {61'b0, err_code}, 64'd1);
    chk("badop_count", {48'b0, cmd_count}, 64'd5);
    chk("badop_idle", {63'b0, busy}, 64'b0);
    push_exp(S_CM, '0, '0, '0, '0, '0);
    cnt_q.push_back(16'd6);
    send_byte(8'h04);
    idle(2);
    chk("post_badop_count", {48'b0, cmd_count}, 64'd6);

    // FULL_RESET: resetting high for 10 cycles
    push_exp(S_FR, '0, '0, '0, '0, '0);
    cnt_q.push_back(16'd7);
    send_byte(8'h06);
    idle(2);
    resetting = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("fr_busy_high", {63'b0, busy}, 64'd1);
    end
    resetting = 1'b0;
    chk("fr_busy_fall", {63'b0, busy}, 64'd1);
    @(negedge clk);
    chk("fr_done", {63'b0, busy}, 64'b0);

`ifdef CMD_ACK_TIMEOUT_EN
    push_exp(S_RW, 8'h00, 9'h000, '0, 16'h0001, '0);
    send_frame(64'h02_00_00_00_01, 5);
    t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("to_cycles", t, 64'd4097);
    chk("to_code", {61'b0, err_code}, 64'd2);
    chk("to_count", {48'b0, cmd_count}, 64'd7);
`endif

    // Reset after 2 of 5 INSTR payload bytes
    send_frame(64'h01_05_DE, 3);
    reset = 1'b1;
    idle(2);
    chk("mid_rst_status", {43'b0, in_byte_ready, busy, error, err_code, cmd_count}, 64'b0);
    chk("mid_rst_targets", {23'b0, block_target, reg_target, ctrl_data}, 64'b0);
    chk("mid_rst_values", {instr_val, buf_init_delay}, 64'b0);
    reset = 1'b0;
    @(negedge clk);
    push_exp(S_INSTR, 8'h07, '0, 32'hCAFEBABE, '0, '0);
    cnt_q.push_back(16'd1);
    send_frame(64'h01_07_CA_FE_BA_BE, 6);
    @(negedge clk);
    instr_write_ack = 1'b1;
    @(negedge clk);
    instr_write_ack = 1'b0;
    chk("post_rst_count", {48'b0, cmd_count}, 64'd1);

    idle(5);
    chk("exp_queue_empty", exp_q.size(), 64'b0);
    chk("cnt_queue_empty", cnt_q.size(), 64'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
